// File: rtl/sseg_update_ctrl.sv
// sseg_update_ctrl: update scheduler for the serial seven-segment display.
// Round-robin arbitration between two frame requesters, frame hold + Start
// pulse to the shifter, completion tracking on seg_pen with a timeout, and
// the free-running blink signal.
// Optional macro SSEG_AUTO_REFRESH_EN: periodic re-send of the held frame
// after REFRESH_CYCLES idle cycles with no request pending.
module sseg_update_ctrl #(
  parameter int FLASH_DIV = 24,
  parameter int TIMEOUT   = 1024,
  parameter int FRAME_W   = 32
`ifdef SSEG_AUTO_REFRESH_EN
  , parameter int REFRESH_CYCLES = 1 << 20
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [FRAME_W-1:0] hexs0,
  input  logic [7:0]         les0,
  input  logic [7:0]         pts0,
  output logic               ack0,
  input  logic               req1,
  input  logic [FRAME_W-1:0] hexs1,
  input  logic [7:0]         les1,
  input  logic [7:0]         pts1,
  output logic               ack1,
  input  logic               seg_pen,
  output logic               Start,
  output logic [FRAME_W-1:0] Hexs,
  output logic [7:0]         LES,
  output logic [7:0]         point,
  output logic               flash,
  output logic               busy,
  output logic               timeout_err
);

  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [FRAME_W-1:0]   hexs_q, hexs_d;
  logic [7:0]           les_q, les_d;
  logic [7:0]           pts_q, pts_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic [TW-1:0]        to_cnt_inc;
  logic                 terr_q, terr_d;
  logic [FLASH_DIV-1:0] fcnt_q, fcnt_d;
  logic                 any_req;
  logic                 win;
  logic                 refresh_due;

  assign any_req = req0 | req1;
  // Contention goes to the requester not served last; otherwise the lone one.
  assign win     = (req0 & req1) ? ~last_grant_q : req1;
  // Saturating so a stuck counter can never wrap back under the limit.
  assign to_cnt_inc = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);

`ifdef SSEG_AUTO_REFRESH_EN
  localparam int IW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  assign refresh_due = (idle_cnt_q == IW'(REFRESH_CYCLES - 1));

  // Idle counter: runs only while parked in IDLE, cleared whenever we leave.
  always_comb begin
    idle_cnt_d = '0;
    if (state_q == IDLE && !any_req && !refresh_due)
      idle_cnt_d = idle_cnt_q + IW'(1);
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`else
  assign refresh_due = 1'b0;
`endif

  // Next-state and datapath: frame is captured on the IDLE->GRANT edge so it
  // is already stable on the device pins during GRANT, a cycle before Start.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hexs_d       = hexs_q;
    les_d        = les_q;
    pts_d        = pts_q;
    to_cnt_d     = to_cnt_q;
    terr_d       = terr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = GRANT;
          last_grant_d = win;
          hexs_d       = win ? hexs1 : hexs0;
          les_d        = win ? les1  : les0;
          pts_d        = win ? pts1  : pts0;
        end else if (refresh_due) begin
          state_d  = START;
          to_cnt_d = '0;
        end
      end
      GRANT: begin
        state_d  = START;
        to_cnt_d = '0;
      end
      START: begin
        state_d  = WAIT_BUSY;
        to_cnt_d = to_cnt_inc;
      end
      WAIT_BUSY: begin
        if (to_cnt_q >= TO_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else if (!seg_pen) begin
          state_d  = WAIT_DONE;
          to_cnt_d = to_cnt_inc;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (seg_pen) begin
          terr_d  = 1'b0;
          state_d = IDLE;
        end else if (to_cnt_q >= TO_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running blink counter, independent of the FSM.
  always_comb begin
    fcnt_d = fcnt_q + FLASH_DIV'(1);
  end

  // State and datapath registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      hexs_q       <= '0;
      les_q        <= '0;
      pts_q        <= '0;
      to_cnt_q     <= '0;
      terr_q       <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hexs_q       <= hexs_d;
      les_q        <= les_d;
      pts_q        <= pts_d;
      to_cnt_q     <= to_cnt_d;
      terr_q       <= terr_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign Start       = (state_q == START);
  assign ack0        = (state_q == GRANT) & ~last_grant_q;
  assign ack1        = (state_q == GRANT) &  last_grant_q;
  assign busy        = (state_q != IDLE);
  assign Hexs        = hexs_q;
  assign LES         = les_q;
  assign point       = pts_q;
  assign timeout_err = terr_q;
  assign flash       = ~fcnt_q[FLASH_DIV-1];

endmodule

// File: tb/tb_sseg_update_ctrl.sv
// Bench for sseg_update_ctrl: directed steps with randomized frames, request
// patterns and shifter timing, checked against a transaction-level model.
module tb_sseg_update_ctrl;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0, req1, seg_pen;
  logic [FW-1:0] hexs0, hexs1;
  logic [7:0]    les0, les1, pts0, pts1;
  logic          ack0, ack1, Start, flash, busy, timeout_err;
  logic [FW-1:0] Hexs;
  logic [7:0]    LES, point;

  int n_cmp = 0;
  int n_err = 0;
  int tcnt;

  logic [31:0] hd[2];
  logic [7:0]  ld[2];
  logic [7:0]  pd[2];
  bit          pend[2];
  int          exp_last;
  bit          exp_terr;

  sseg_update_ctrl #(.FLASH_DIV(4), .TIMEOUT(16), .FRAME_W(FW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .hexs0(hexs0), .les0(les0), .pts0(pts0), .ack0(ack0),
    .req1(req1), .hexs1(hexs1), .les1(les1), .pts1(pts1), .ack1(ack1),
    .seg_pen(seg_pen), .Start(Start), .Hexs(Hexs), .LES(LES), .point(point),
    .flash(flash), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Cycles since reset release, the reference for the blink pattern.
  always @(posedge clk or negedge rst)
    if (!rst) tcnt <= 0;
    else      tcnt <= tcnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0 = pend[0]; hexs0 = hd[0]; les0 = ld[0]; pts0 = pd[0];
    req1 = pend[1]; hexs1 = hd[1]; les1 = ld[1]; pts1 = pd[1];
  endtask

  // FLASH_DIV=4: eight cycles high then eight low, from reset.
  task automatic tick();
    @(posedge clk); #1;
    chk("flash", flash, (tcnt % 16) < 8);
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    hd[i]   = $urandom;
    ld[i]   = 8'($urandom);
    pd[i]   = 8'($urandom);
    drive();
  endtask

  task automatic mid(input logic [31:0] fh, input logic [7:0] fl, input logic [7:0] fp, input bit te);
    chk("start_low", Start, 1'b0);
    chk("no_ack", {ack0, ack1}, 2'b00);
    chk("busy_hi", busy, 1'b1);
    chk("hexs_hold", Hexs, fh);
    chk("les_hold", LES, fl);
    chk("pts_hold", point, fp);
    chk("terr_hold", timeout_err, te);
  endtask

  // One transfer: requests are already on the pins and the DUT is in IDLE.
  task automatic serve(input int w, input int lat, input int len, input bit [1:0] raise);
    logic [31:0] fh;
    logic [7:0]  fl, fp;
    bit          te;
    te = exp_terr;
    tick();
    chk("ack0", ack0, w == 0);
    chk("ack1", ack1, w == 1);
    chk("hexs_cap", Hexs, hd[w]);
    chk("les_cap", LES, ld[w]);
    chk("pts_cap", point, pd[w]);
    chk("busy_grant", busy, 1'b1);
    chk("start_grant", Start, 1'b0);
    chk("terr_grant", timeout_err, te);
    fh = hd[w]; fl = ld[w]; fp = pd[w];
    exp_last = w;
    pend[w] = 1'b0;
    hd[w] = $urandom;
    drive();
    tick();
    chk("start", Start, 1'b1);
    chk("no_ack_start", {ack0, ack1}, 2'b00);
    chk("hexs_start", Hexs, fh);
    for (int i = 0; i < lat; i++) begin tick(); mid(fh, fl, fp, te); end
    seg_pen = 1'b0;
    for (int i = 0; i < len; i++) begin
      tick(); mid(fh, fl, fp, te);
      if (i == 0)
        for (int j = 0; j < 2; j++)
          if (raise[j] && !pend[j]) new_req(j);
    end
    seg_pen = 1'b1;
    tick();
    chk("busy_done", busy, 1'b0);
    chk("terr_done", timeout_err, 1'b0);
    chk("no_ack_done", {ack0, ack1}, 2'b00);
    chk("hexs_done", Hexs, fh);
    exp_terr = 1'b0;
  endtask

  function automatic int model_winner();
    if (pend[0] && pend[1]) return 1 - exp_last;
    return pend[0] ? 0 : 1;
  endfunction

  initial begin
    bit [1:0] r;
    int       w;
    seg_pen = 1'b1;
    for (int i = 0; i < 2; i++) begin pend[i] = 0; hd[i] = '0; ld[i] = '0; pd[i] = '0; end
    drive();
    exp_last = 1;
    exp_terr = 1'b0;
    #3;
    chk("rst_start", Start, 1'b0);
    chk("rst_ack", {ack0, ack1}, 2'b00);
    chk("rst_hexs", Hexs, 32'h0);
    chk("rst_les", LES, 8'h0);
    chk("rst_pts", point, 8'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_flash", flash, 1'b1);

    // Both requesting from reset: alternating grants 0,1,0,1.
    new_req(0); new_req(1);
    #20 rst = 1'b1;
    for (int k = 0; k < 4; k++)
      serve(k % 2, $urandom_range(1, 3), $urandom_range(1, 8), (k < 2) ? 2'(1 << k) : 2'b00);

    // Fixed frame from requester 0 alone.
    pend[0] = 1'b1; hd[0] = 32'h1234_ABCD; ld[0] = 8'hFF; pd[0] = 8'h01;
    drive();
    serve(0, 2, 5, 2'b00);

    // Random traffic, with requests raised mid-transfer (during WAIT_DONE).
    for (int it = 0; it < 20; it++) begin
      if (!pend[0] && !pend[1]) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          tick();
          chk("idle_busy", busy, 1'b0);
          chk("idle_start", Start, 1'b0);
        end
        r = 2'($urandom_range(1, 3));
        if (r[0]) new_req(0);
        if (r[1]) new_req(1);
      end
      w = model_winner();
      serve(w, $urandom_range(1, 3), $urandom_range(1, 8), 2'($urandom_range(0, 3)));
    end
    while (pend[0] || pend[1]) serve(model_winner(), 1, 2, 2'b00);

    // Shifter never responds: timeout after 16 cycles, back to IDLE.
    new_req(0);
    tick();
    chk("to_ack0", ack0, 1'b1);
    pend[0] = 1'b0; drive(); exp_last = 0;
    tick();
    chk("to_start", Start, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("to_terr", timeout_err, k == 16);
      chk("to_busy", busy, k < 16);
    end
    exp_terr = 1'b1;
    tick();
    chk("to_sticky", timeout_err, 1'b1);
    new_req(1);
    serve(model_winner(), 2, 3, 2'b00);

    // Reset during WAIT_DONE with req0 still held.
    new_req(0);
    tick();
    chk("rr_ack0", ack0, 1'b1);
    tick();
    chk("rr_start", Start, 1'b1);
    seg_pen = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rr_start0", Start, 1'b0);
    chk("rr_ack", {ack0, ack1}, 2'b00);
    chk("rr_hexs", Hexs, 32'h0);
    chk("rr_les", LES, 8'h0);
    chk("rr_pts", point, 8'h0);
    chk("rr_busy", busy, 1'b0);
    chk("rr_terr", timeout_err, 1'b0);
    chk("rr_flash", flash, 1'b1);
    seg_pen = 1'b1;
    #2 rst = 1'b1;
    exp_last = 1;
    exp_terr = 1'b0;
    serve(0, 1, 4, 2'b00);

    // A stretch of idle cycles to cover the blink wrap.
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("tail_busy", busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sseg_update_ctrl.md
Name: sseg_update_ctrl

Overview:
Update scheduler for the serial seven-segment display device (the hex-to-segment encoder plus parallel-to-serial shifter).
- Arbitrates display frames from two requesters (e.g. CPU datapath and debug monitor) with round-robin priority.
- Holds the granted frame stable on the device inputs and issues the Start pulse to the shifter.
- Tracks the shifter's SEG_PEN to detect transfer completion, with a timeout.
- Generates the free-running blink (flash) signal.

Parameters:
FLASH_DIV, 24, flash counter width; flash toggles every 2^(FLASH_DIV-1) cycles
TIMEOUT, 1024, max cycles from Start to transfer completion before abort
FRAME_W, 32, hex frame width (8 digits x 4 bits)
REFRESH_CYCLES, 2^20, idle cycles between automatic re-sends (optional feature only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
req0  in  1  requester 0 frame request; held high until ack0
hexs0  in  FRAME_W  requester 0 hex digits
les0  in  8  requester 0 per-digit enable
pts0  in  8  requester 0 decimal points
ack0  out  1  one-cycle grant/capture strobe for requester 0
req1, hexs1, les1, pts1, ack1  same as requester 0, for requester 1
seg_pen  in  1  SEG_PEN from device; 0 while shifting, 1 when idle/latched
Start  out  1  one-cycle start pulse to device
Hexs  out  FRAME_W  registered frame to device
LES  out  8  registered digit enables to device
point  out  8  registered decimal points to device
flash  out  1  blink signal to device
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky transfer-timeout flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - Hexs=0, LES=0, point=0, Start=0, ack0=ack1=0, busy=0, timeout_err=0.
  - Flash counter=0, so flash=1.
  - last_grant=1, so requester 0 wins first.
- Reset mid-transfer aborts immediately. No ack is reissued; requesters keep req high and are served after reset.
- FSM states: IDLE -> GRANT -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
- IDLE:
  - If req0|req1, select the winner and go to GRANT next cycle.
  - Only one requesting: that one wins.
  - Both requesting: the one not equal to last_grant wins.
- GRANT:
  - Capture the winner's hexs/les/pts into Hexs/LES/point.
  - Pulse ackN=1 for exactly this cycle; update last_grant.
  - Requester may drop or change req/data from the next cycle.
- START: Start=1 for exactly one cycle. Hexs/LES/point are stable at least one cycle before Start (since GRANT) and stay stable until return to IDLE.
- WAIT_BUSY: wait for seg_pen=0 (shift begun), then go to WAIT_DONE.
- WAIT_DONE: wait for seg_pen=1 (shift complete), clear timeout_err, go to IDLE. busy drops the cycle after.
- Timeout:
  - The timeout counter clears on entry to START and counts in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT-1 without completion: set timeout_err and go to IDLE.
  - The frame is considered delivered (no retry). Ack was already given.
- Latency: req sampled high in IDLE at cycle N -> ack at N+1 -> Start at N+2. A back-to-back request is seen in IDLE at the earliest one cycle after completion.
- Requests arriving while busy are held by the requester. Only the req level is sampled, and only in IDLE.
- A req dropped before ack is simply not served.
- flash = ~cnt[FLASH_DIV-1]:
  - Free-running, wraps modulo 2^FLASH_DIV.
  - Independent of FSM state.
- Widths: counters unsigned. TIMEOUT counter is clog2(TIMEOUT) bits and saturates.

Optional Feature:
Macro SSEG_AUTO_REFRESH_EN.
- Defined:
  - An idle counter runs in IDLE and clears on leaving IDLE.
  - If it reaches REFRESH_CYCLES-1 with no req pending, go directly to START and re-send the current Hexs/LES/point. No ack is generated and last_grant is unchanged.
  - A real req in the same cycle as expiry wins.
- Undefined: no idle counter; the FSM leaves IDLE only on a request.

Test Plan:
- Reset release; req0=1, hexs0=32'h1234_ABCD, les0=8'hFF, pts0=8'h01 -> ack0 1 cycle later, Start 2 cycles later, Hexs=32'h1234_ABCD stable until busy=0.
- req0 and req1 high together from reset; device model holds seg_pen low 64 cycles per frame -> grant order 0,1,0,1; exactly one ack per grant.
- req1 raised during WAIT_DONE of requester 0 -> no ack1 until after seg_pen returns 1; then ack1 within 2 cycles.
- seg_pen held 1 forever after Start, TIMEOUT=16 -> timeout_err=1 exactly 16 cycles after Start, FSM back in IDLE; next normal transfer clears timeout_err.
- rst=0 asserted in WAIT_DONE -> all outputs 0 and flash=1 asynchronously; after release with req still high -> transfer restarts from GRANT.
- FLASH_DIV=4 -> flash=1 for 8 cycles then 0 for 8 cycles, repeating. With SSEG_AUTO_REFRESH_EN and REFRESH_CYCLES=100, idle -> Start every 100 cycles plus transfer time, no ack.
